// File: rtl/pcs_tx_skp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_skp_scheduler
// Brief    : Shares the PCS TX encoder slot between MAC symbols and periodic
//            SKP ordered sets (COM + SKP_LEN x SKP), never splitting a packet.
//            Optional macro SKP_SCHED_STATS_EN adds the Skp_Count output.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_skp_scheduler #(
  parameter int         SKP_INTERVAL = 1180,
  parameter int         SKP_LEN      = 3,
  parameter logic [7:0] COM_SYM      = 8'hBC,
  parameter logic [7:0] SKP_SYM      = 8'h1C,
  parameter logic [7:0] STP_SYM      = 8'hFB,
  parameter logic [7:0] END_SYM      = 8'hFD
) (
  input  logic        PCLK,
  input  logic        RST,
  input  logic        SKP_Enable,
  input  logic [7:0]  MAC_TX_Data,
  input  logic        MAC_TX_Datak,
  input  logic        MAC_Data_En,
  output logic        MAC_Ready,
  output logic [7:0]  Sched_Data,
  output logic        Sched_Datak,
  output logic        Sched_Valid,
`ifdef SKP_SCHED_STATS_EN
  output logic [15:0] Skp_Count,
`endif
  output logic        Skp_Active
);

  localparam int CNT_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_COM  = 2'd1,
    ST_SKP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] interval_cnt_q, interval_cnt_d;
  logic       skp_pending_q, skp_pending_d;
  logic       in_pkt_q, in_pkt_d;
  logic [2:0] skp_cnt_q, skp_cnt_d;
  logic [7:0] data_q, data_d;
  logic       datak_q, datak_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic       mac_accept;
  logic       expire;
  logic       last_skp;

  // Ready depends only on registered state so the MAC sees no comb path back.
  assign MAC_Ready  = (state_q == ST_DATA) && !(skp_pending_q && !in_pkt_q);
  assign mac_accept = MAC_Data_En && MAC_Ready;
  assign expire     = SKP_Enable && (interval_cnt_q == CNT_W'(SKP_INTERVAL - 1));
  assign last_skp   = (state_q == ST_SKP) && (skp_cnt_q == 3'(SKP_LEN - 1));

  always_comb begin
    state_d        = state_q;
    interval_cnt_d = interval_cnt_q;
    skp_pending_d  = skp_pending_q;
    in_pkt_d       = in_pkt_q;
    skp_cnt_d      = skp_cnt_q;
    data_d         = 8'h00;
    datak_d        = 1'b0;
    valid_d        = 1'b0;
    active_d       = 1'b0;

    if (SKP_Enable) begin
      interval_cnt_d = expire ? '0 : interval_cnt_q + 1'b1;
    end else begin
      interval_cnt_d = '0;
    end

    case (state_q)
      ST_DATA: begin
        if (skp_pending_q && !in_pkt_q) begin
          state_d       = ST_COM;
          skp_pending_d = 1'b0;
        end else if (mac_accept) begin
          data_d  = MAC_TX_Data;
          datak_d = MAC_TX_Datak;
          valid_d = 1'b1;
          if (MAC_TX_Datak && (MAC_TX_Data == STP_SYM)) begin
            in_pkt_d = 1'b1;
          end else if (MAC_TX_Datak && (MAC_TX_Data == END_SYM)) begin
            in_pkt_d = 1'b0;
          end
        end
      end
      ST_COM: begin
        data_d    = COM_SYM;
        datak_d   = 1'b1;
        valid_d   = 1'b1;
        active_d  = 1'b1;
        skp_cnt_d = 3'd0;
        state_d   = ST_SKP;
      end
      ST_SKP: begin
        data_d    = SKP_SYM;
        datak_d   = 1'b1;
        valid_d   = 1'b1;
        active_d  = 1'b1;
        skp_cnt_d = skp_cnt_q + 3'd1;
        if (last_skp) begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase

    // A fresh expiry outranks the clear on service, so no request is lost.
    if (expire) begin
      skp_pending_d = 1'b1;
    end
    if (!SKP_Enable && (state_q == ST_DATA)) begin
      skp_pending_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_q        <= ST_DATA;
      interval_cnt_q <= '0;
      skp_pending_q  <= 1'b0;
      in_pkt_q       <= 1'b0;
      skp_cnt_q      <= 3'd0;
      data_q         <= 8'h00;
      datak_q        <= 1'b0;
      valid_q        <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      interval_cnt_q <= interval_cnt_d;
      skp_pending_q  <= skp_pending_d;
      in_pkt_q       <= in_pkt_d;
      skp_cnt_q      <= skp_cnt_d;
      data_q         <= data_d;
      datak_q        <= datak_d;
      valid_q        <= valid_d;
      active_q       <= active_d;
    end
  end

  assign Sched_Data  = data_q;
  assign Sched_Datak = datak_q;
  assign Sched_Valid = valid_q;
  assign Skp_Active  = active_q;

`ifdef SKP_SCHED_STATS_EN
  logic [15:0] skp_count_q, skp_count_d;

  always_comb begin
    skp_count_d = skp_count_q;
    if (last_skp && (skp_count_q != 16'hFFFF)) begin
      skp_count_d = skp_count_q + 16'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (RST) begin
      skp_count_q <= 16'd0;
    end else begin
      skp_count_q <= skp_count_d;
    end
  end

  assign Skp_Count = skp_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_skp_scheduler.sv
`default_nettype none
// Directed bench for pcs_tx_skp_scheduler (SKP_INTERVAL=20, SKP_LEN=3).
// Call k of chk() samples the outputs left by the k-th edge after reset.
module tb_pcs_tx_skp_scheduler;

  logic        PCLK = 1'b0;
  logic        RST = 1'b1;
  logic        SKP_Enable = 1'b0;
  logic [7:0]  MAC_TX_Data = 8'h00;
  logic        MAC_TX_Datak = 1'b0;
  logic        MAC_Data_En = 1'b0;
  logic        MAC_Ready;
  logic [7:0]  Sched_Data;
  logic        Sched_Datak;
  logic        Sched_Valid;
  logic        Skp_Active;
`ifdef SKP_SCHED_STATS_EN
  logic [15:0] Skp_Count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pcs_tx_skp_scheduler #(.SKP_INTERVAL(20), .SKP_LEN(3)) dut (
    .PCLK         (PCLK),
    .RST          (RST),
    .SKP_Enable   (SKP_Enable),
    .MAC_TX_Data  (MAC_TX_Data),
    .MAC_TX_Datak (MAC_TX_Datak),
    .MAC_Data_En  (MAC_Data_En),
    .MAC_Ready    (MAC_Ready),
    .Sched_Data   (Sched_Data),
    .Sched_Datak  (Sched_Datak),
    .Sched_Valid  (Sched_Valid),
`ifdef SKP_SCHED_STATS_EN
    .Skp_Count    (Skp_Count),
`endif
    .Skp_Active   (Skp_Active)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       k;
    logic       de;
    logic       e_rdy;
    logic [7:0] e_d;
    logic       e_k;
    logic       e_v;
    logic       e_a;
  } vec_t;

  vec_t tbl [8];

  // Drive next-edge inputs at a negedge, check current outputs, advance one cycle.
  task automatic chk(input string name, input logic rst, input logic en,
                     input logic [7:0] d, input logic k, input logic de,
                     input logic e_rdy, input logic [7:0] e_d, input logic e_k,
                     input logic e_v, input logic e_a);
    RST = rst; SKP_Enable = en; MAC_TX_Data = d; MAC_TX_Datak = k; MAC_Data_En = de;
    #1;
    n_tests++;
    if ({MAC_Ready, Sched_Data, Sched_Datak, Sched_Valid, Skp_Active} !==
        {e_rdy, e_d, e_k, e_v, e_a}) begin
      n_fail++;
      $display("FAIL %s @%0t: got rdy=%b d=%h k=%b v=%b act=%b, want rdy=%b d=%h k=%b v=%b act=%b",
               name, $time, MAC_Ready, Sched_Data, Sched_Datak, Sched_Valid, Skp_Active,
               e_rdy, e_d, e_k, e_v, e_a);
    end
    @(negedge PCLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; SKP_Enable = 1'b0; MAC_Data_En = 1'b0;
    MAC_TX_Data = 8'h00; MAC_TX_Datak = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  // Expected outputs with no MAC traffic, r edges after counting started:
  // pending at r=20+20j, bubble at r=21+20j, COM at 22+20j, SKPs at 23..25+20j.
  task automatic exp_periodic(input int r, output logic rdy, output logic [7:0] d,
                              output logic k, output logic v, output logic a);
    int ph;
    rdy = 1'b1; d = 8'h00; k = 1'b0; v = 1'b0; a = 1'b0;
    if (r >= 20) begin
      ph = (r - 20) % 20;
      if (ph <= 4) rdy = 1'b0;
      if (ph >= 2 && ph <= 5) begin
        d = (ph == 2) ? 8'hBC : 8'h1C;
        k = 1'b1; v = 1'b1; a = 1'b1;
      end
    end
  endtask

  initial begin
    logic       er, ek, ev, ea;
    logic [7:0] ed;

    // Pass-through of a short packet, no SKP pending.
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'hFB, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFB, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'hFD, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFD, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

    // Reset defaults, then a long idle stretch with SKP disabled.
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      chk("idle_disabled", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("passthru[%0d]", i), tbl[i].rst, tbl[i].en, tbl[i].d, tbl[i].k,
          tbl[i].de, tbl[i].e_rdy, tbl[i].e_d, tbl[i].e_k, tbl[i].e_v, tbl[i].e_a);
    end

    // Periodic insertion with an idle MAC: three ordered sets.
    do_reset();
    for (int c = 0; c <= 66; c++) begin
      exp_periodic(c, er, ed, ek, ev, ea);
      chk($sformatf("periodic[%0d]", c), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, er, ed, ek, ev, ea);
    end
`ifdef SKP_SCHED_STATS_EN
    n_tests++;
    if (Skp_Count !== 16'd3) begin
      n_fail++;
      $display("FAIL skp_count_after3: got %0d, want 3", Skp_Count);
    end
`endif

    // Reset on the cycle the second SKP is presented.
    do_reset();
`ifdef SKP_SCHED_STATS_EN
    #1;
    n_tests++;
    if (Skp_Count !== 16'd0) begin
      n_fail++;
      $display("FAIL skp_count_reset: got %0d, want 0", Skp_Count);
    end
    @(negedge PCLK);
    do_reset();
`endif
    for (int c = 0; c <= 23; c++) begin
      exp_periodic(c, er, ed, ek, ev, ea);
      chk($sformatf("pre_rst[%0d]", c), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, er, ed, ek, ev, ea);
    end
    chk("rst_at_skp2", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b1, 1'b1, 1'b1);
    for (int c = 25; c <= 49; c++) begin
      exp_periodic(c - 25, er, ed, ek, ev, ea);
      chk($sformatf("post_rst[%0d]", c), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, er, ed, ek, ev, ea);
    end

    // Deferral: request expires mid-packet, ordered set follows the END.
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      logic [7:0] d;
      logic       k, de;
      d = 8'h00; k = 1'b0; de = 1'b0;
      er = 1'b1; ed = 8'h00; ek = 1'b0; ev = 1'b0; ea = 1'b0;
      if (c == 14) begin d = 8'hFB; k = 1'b1; de = 1'b1; end
      else if (c >= 15 && c <= 23) begin d = 8'(c - 14); de = 1'b1; end
      else if (c == 24) begin d = 8'hFD; k = 1'b1; de = 1'b1; end
      else if (c >= 25 && c <= 30) begin d = 8'h55; de = 1'b1; end
      if (c == 15) begin ed = 8'hFB; ek = 1'b1; ev = 1'b1; end
      else if (c >= 16 && c <= 24) begin ed = 8'(c - 15); ev = 1'b1; end
      else if (c == 25) begin ed = 8'hFD; ek = 1'b1; ev = 1'b1; end
      else if (c == 27) begin ed = 8'hBC; ek = 1'b1; ev = 1'b1; ea = 1'b1; end
      else if (c >= 28 && c <= 30) begin ed = 8'h1C; ek = 1'b1; ev = 1'b1; ea = 1'b1; end
      else if (c == 31) begin ed = 8'h55; ev = 1'b1; end
      if (c >= 25 && c <= 29) er = 1'b0;
      chk($sformatf("defer[%0d]", c), 1'b0, 1'b1, d, k, de, er, ed, ek, ev, ea);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcs_tx_skp_scheduler.md
Name: pcs_tx_skp_scheduler

Overview:
- Sits between the MAC TX symbol stream and the PCS TX encoder.
- Periodically schedules SKP ordered sets (COM followed by SKP_LEN SKP symbols), sharing the single encoder input slot between MAC traffic and SKP insertion.
- Never splits a packet. Defers insertion until the packet boundary, then back-pressures the MAC via MAC_Ready for the duration of the ordered set.

Parameters:
- SKP_INTERVAL, 1180: PCLK cycles between SKP scheduling requests. Legal values are > SKP_LEN+2.
- SKP_LEN, 3: number of SKP symbols after COM. Legal range 1..5.
- COM_SYM, 8'hBC: K28.5 comma symbol.
- SKP_SYM, 8'h1C: K28.0 skip symbol.
- STP_SYM, 8'hFB: K27.7 packet-start symbol.
- END_SYM, 8'hFD: K29.7 packet-end symbol.

Ports:
- PCLK  in  1  symbol clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- SKP_Enable  in  1  config; 1 = periodic SKP insertion enabled.
- MAC_TX_Data  in  8  MAC symbol.
- MAC_TX_Datak  in  1  1 = MAC_TX_Data is a K-symbol.
- MAC_Data_En  in  1  MAC symbol valid.
- MAC_Ready  out  1  scheduler accepts a MAC symbol this cycle.
- Sched_Data  out  8  symbol to encoder.
- Sched_Datak  out  1  K flag to encoder.
- Sched_Valid  out  1  Sched_Data valid.
- Skp_Active  out  1  ordered set currently being emitted.

Behaviour:
- Reset (RST=1 at an edge): state=DATA, interval_cnt=0, skp_pending=0, in_pkt=0, skp_cnt=0. Outputs: Sched_Data=8'h00, Sched_Datak=0, Sched_Valid=0, Skp_Active=0. Reset mid-ordered-set aborts it immediately; no resumption.
- Accept rule: a MAC symbol transfers when MAC_Data_En && MAC_Ready.
- MAC_Ready is combinational from registers only: MAC_Ready = (state==DATA) && !(skp_pending && !in_pkt).
- in_pkt: set on an accepted STP_SYM with k=1. Cleared on an accepted END_SYM with k=1. An accepted STP while in_pkt=1 keeps in_pkt=1.
- interval_cnt: counts every cycle while SKP_Enable=1. On reaching SKP_INTERVAL-1 it wraps to 0 and sets skp_pending. If skp_pending is already 1 the request merges; at most one pending request exists.
- SKP_Enable=0: interval_cnt holds at 0. skp_pending is cleared if state==DATA. An ordered set already in progress completes.
- State machine:
  - DATA: if skp_pending && !in_pkt, go to COM, clear skp_pending, and output an idle bubble this cycle. Otherwise pass the MAC symbol through.
  - COM: output COM_SYM, k=1. skp_cnt <= 0. Go to SKP.
  - SKP: output SKP_SYM, k=1. skp_cnt++. When skp_cnt==SKP_LEN-1, go to DATA.
- Output registers:
  - Accepted MAC symbol appears on Sched_* the next cycle with Sched_Valid=1. Latency is 1 cycle.
  - No accepted symbol in DATA: next cycle Sched_Data=8'h00, Sched_Datak=0, Sched_Valid=0.
  - COM/SKP emissions: Sched_Valid=1 and Skp_Active=1 on the same cycle the symbol is presented.
- Ordered set on the output: exactly 1+SKP_LEN consecutive valid cycles, preceded by one idle bubble.
- Deferral: a request raised while in_pkt=1 waits. The END symbol is accepted; in_pkt drops the next cycle; MAC_Ready falls that same cycle.
- Simultaneous events:
  - Expiry during COM/SKP sets skp_pending; it is serviced on the next DATA cycle.
  - MAC_Data_En while MAC_Ready=0: the symbol is not consumed. The MAC must hold it.

Optional Feature:
- Macro: SKP_SCHED_STATS_EN.
- Defined: adds output Skp_Count [15:0], a saturating count of completed ordered sets. It increments when the last SKP symbol is emitted, holds at 16'hFFFF, and is cleared by RST.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset defaults: RST=1 for 3 cycles, then 0 with SKP_Enable=0 and MAC idle → Sched_Valid=0, Sched_Data=00, MAC_Ready=1, and no ordered set for 5000 cycles.
- Periodic insertion: SKP_INTERVAL=20, SKP_LEN=3, SKP_Enable=1, no MAC traffic → every 20 cycles: one bubble, then BC/k1, 1C/k1, 1C/k1, 1C/k1, with Skp_Active=1 for those 4 cycles.
- Pass-through: MAC streams FB(k) 01 02 03 FD(k) with no pending request → same symbols on Sched_* one cycle later, Sched_Valid=1, MAC_Ready constantly 1.
- Deferral: request expires mid-packet after STP → MAC_Ready stays 1 through the FD acceptance. It falls the next cycle, and BC 1C 1C 1C follows FD plus one bubble. MAC data held during back-pressure appears afterward unaltered.
- Mid-ordered-set reset: RST=1 on the cycle the second 1C is output → next cycle all outputs 0, state DATA, MAC_Ready=1; the first post-reset ordered set comes SKP_INTERVAL cycles later.
- With SKP_SCHED_STATS_EN: 3 complete ordered sets → Skp_Count=3; RST → 0.
